// File: rtl/segfx_pkg.sv
// Shared constants for the seven-segment effect sequencer.
package segfx_pkg;

  localparam int unsigned CNT_W_DEF = 3;
  localparam int unsigned DIV_W_DEF = 16;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/segfx_prescaler.sv
// Programmable step-rate divider: o_adv fires once every i_div+1 running clocks.
module segfx_prescaler
  import segfx_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_adv
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             hit;

  // Terminal detect uses >= so lowering i_div below the current phase advances at once.
  always_comb begin
    hit     = (presc_q >= i_div);
    o_adv   = i_run & ~i_clr & hit;
    presc_d = presc_q;
    if (i_clr) begin
      presc_d = '0;
    end else if (i_run) begin
      presc_d = hit ? '0 : presc_q + DIV_W'(1);
    end
  end

  // Prescaler phase register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/segfx_sequencer.sv
// Pattern index sequencer: up/down/ping-pong/manual stepping at a prescaled rate.
module segfx_sequencer
  import segfx_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_step,
  input  logic             i_sync,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick,
  output logic             o_wrap,
  output logic             o_dir
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             step_q;
  logic             hold;
  logic             presc_adv;
  logic             adv;

  assign hold = (i_mode == MODE_HOLD);

  segfx_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_sync | (i_en & hold)),
    .i_run (i_en & ~hold),
    .i_div (i_div),
    .o_adv (presc_adv)
  );

  // Advance source: manual step edge in hold mode, prescaler otherwise.
  assign adv = hold ? (i_en & i_step & ~step_q) : presc_adv;

  // Index/direction next state; sync outranks freeze, freeze outranks advance.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (i_sync) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (i_en && adv) begin
      tick_d = 1'b1;
      unique case (i_mode)
        MODE_DOWN: begin
          dir_d = DIR_DOWN;
          if (count_q == '0) begin
            count_d = CNT_MAX;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        MODE_PP: begin
          if (dir_q == DIR_UP) begin
            if (count_q == CNT_MAX) begin
              dir_d   = DIR_DOWN;
              count_d = CNT_MAX - CNT_W'(1);
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end else begin
            if (count_q == '0) begin
              dir_d   = DIR_UP;
              count_d = CNT_W'(1);
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        default: begin
          dir_d = DIR_UP;
          if (count_q == CNT_MAX) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Output and step-history registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      step_q  <= i_step;
    end
  end

  assign o_count = count_q;
  assign o_dir   = dir_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_segfx_sequencer.sv
// Scoreboard bench for segfx_sequencer with directed scenarios and a random soak.
module tb_segfx_sequencer;

  typedef struct packed {
    logic [2:0] cnt;
    logic       tick;
    logic       wrap;
    logic       dir;
  } exp_t;

  logic        clk;
  logic        rst, en, step, sync;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [2:0]  o_count;
  logic        o_tick, o_wrap, o_dir;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_no = 0;
  int tick_cnt, wrap_cnt;
  int m_cnt, m_dir, m_presc, m_stepq, m_tick, m_wrap;
  exp_t sb_q[$];

  segfx_sequencer dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_mode  (mode),
    .i_div   (div),
    .i_step  (step),
    .i_sync  (sync),
    .o_count (o_count),
    .o_tick  (o_tick),
    .o_wrap  (o_wrap),
    .o_dir   (o_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc_no, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge given the currently driven inputs.
  task automatic model_step();
    int adv;
    if (rst) begin
      m_cnt = 0; m_dir = 0; m_presc = 0; m_stepq = 0; m_tick = 0; m_wrap = 0;
    end else begin
      adv = 0; m_tick = 0; m_wrap = 0;
      if (sync) begin
        m_cnt = 0; m_dir = 0; m_presc = 0;
      end else if (en) begin
        if (mode == 2'b11) begin
          adv = (step && !m_stepq) ? 1 : 0;
          m_presc = 0;
        end else if (m_presc >= int'(div)) begin
          adv = 1;
          m_presc = 0;
        end else begin
          m_presc++;
        end
        if (adv != 0) begin
          m_tick = 1;
          if (mode == 2'b01) begin
            m_dir  = 1;
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + 7) % 8;
          end else if (mode == 2'b10) begin
            if (m_dir == 0 && m_cnt == 7) begin
              m_dir = 1; m_cnt = 6; m_wrap = 1;
            end else if (m_dir == 1 && m_cnt == 0) begin
              m_dir = 0; m_cnt = 1; m_wrap = 1;
            end else begin
              m_cnt = (m_dir == 0) ? m_cnt + 1 : m_cnt - 1;
            end
          end else begin
            m_dir  = 0;
            m_wrap = (m_cnt == 7);
            m_cnt  = (m_cnt + 1) % 8;
          end
        end
      end
      m_stepq = step;
    end
  endtask

  // One clock: predict, push, let the edge happen, pop and compare.
  task automatic cyc();
    exp_t e, got;
    model_step();
    e.cnt = 3'(m_cnt); e.tick = 1'(m_tick); e.wrap = 1'(m_wrap); e.dir = 1'(m_dir);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    got = sb_q.pop_front();
    chk("count", 32'(o_count), 32'(got.cnt));
    chk("tick",  32'(o_tick),  32'(got.tick));
    chk("wrap",  32'(o_wrap),  32'(got.wrap));
    chk("dir",   32'(o_dir),   32'(got.dir));
    if (o_tick === 1'b1) tick_cnt++;
    if (o_wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Clocks until the next tick, bounded so a dead DUT cannot hang the run.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (o_tick !== 1'b1 && n < 64);
  endtask

  initial begin
    int n;
    rst = 1'b1; sync = 1'b1; en = 1'b1; mode = 2'b10; div = 16'd0; step = 1'b1;

    // Reset dominates arbitrary inputs.
    run(2);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_dir",   32'(o_dir),   32'd0);
    chk("rst_tick",  32'(o_tick),  32'd0);

    // Up mode, period 4: eight advances in 32 clocks, one wrap.
    rst = 1'b0; sync = 1'b0; step = 1'b0; mode = 2'b00; div = 16'd3;
    tick_cnt = 0; wrap_cnt = 0;
    run(32);
    chk("up_ticks", 32'(tick_cnt), 32'd8);
    chk("up_wraps", 32'(wrap_cnt), 32'd1);
    chk("up_count", 32'(o_count), 32'd0);

    // Ping-pong at full rate, endpoints not repeated.
    sync = 1'b1; div = 16'd0; run(1);
    sync = 1'b0; mode = 2'b10; wrap_cnt = 0;
    run(7);
    chk("pp_top",     32'(o_count), 32'd7);
    chk("pp_top_dir", 32'(o_dir),   32'd0);
    run(1);
    chk("pp_turn",     32'(o_count), 32'd6);
    chk("pp_turn_dir", 32'(o_dir),   32'd1);
    run(6);
    chk("pp_bot", 32'(o_count), 32'd0);
    run(1);
    chk("pp_rise",     32'(o_count), 32'd1);
    chk("pp_rise_dir", 32'(o_dir),   32'd0);
    chk("pp_wraps",    32'(wrap_cnt), 32'd2);

    // Hold: a long step level is one advance; same level in up mode adds none.
    mode = 2'b11; step = 1'b0; run(2);
    tick_cnt = 0;
    step = 1'b1; run(5);
    step = 1'b0; run(2);
    chk("hold_ticks", 32'(tick_cnt), 32'd1);
    mode = 2'b00; div = 16'd1000; tick_cnt = 0;
    step = 1'b1; run(5);
    step = 1'b0; run(2);
    chk("up_step_ignored", 32'(tick_cnt), 32'd0);

    // Sync from ping-pong mid-descent, then first tick div+1 clocks later.
    sync = 1'b1; run(1);
    sync = 1'b0; mode = 2'b10; div = 16'd0;
    run(9);
    chk("pp5_count", 32'(o_count), 32'd5);
    chk("pp5_dir",   32'(o_dir),   32'd1);
    sync = 1'b1; div = 16'd4; run(1);
    sync = 1'b0;
    chk("sync_count", 32'(o_count), 32'd0);
    chk("sync_dir",   32'(o_dir),   32'd0);
    wait_tick(n);
    chk("sync_lat", 32'(n), 32'd5);

    // Lowering div below the prescaler phase advances next clock.
    mode = 2'b00; div = 16'd100; sync = 1'b1; run(1);
    sync = 1'b0; run(50);
    div = 16'd2;
    wait_tick(n);
    chk("div_drop_lat", 32'(n), 32'd1);
    wait_tick(n);
    chk("div_period", 32'(n), 32'd3);
    en = 1'b0; tick_cnt = 0;
    run(5);
    chk("freeze_count", 32'(o_count), 32'd2);
    chk("freeze_ticks", 32'(tick_cnt), 32'd0);

    // Random soak against the scoreboard model.
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(99) == 0);
      sync = ($urandom_range(29) == 0);
      en   = ($urandom_range(99) < 85);
      if ($urandom_range(9) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) div  = 16'($urandom_range(5));
      step = 1'($urandom_range(1));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
